test1_bus_arb: RTL and testbench

Arbitrates two `test1`-class sources, `rcv` and `foo`, onto one shared 17-bit bus, so their `wire4`-style outputs are never driven concurrently. Each source presents a 4-bit tag and 17-bit data under a req/gnt handshake. The arbiter captures the winner's payload and drives it on the shared bus under a valid/ready handshake. It also produces registered `eq`/`not_eq` flags by comparing the captured tag against a configured match tag.

---
 rtl/test1_bus_arb.sv | 163 ++++++++++++++++
 tb/tb_test1_bus_arb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/test1_bus_arb.sv
// test1_bus_arb: two-source (rcv, foo) round-robin arbiter onto a shared bus.
// The winner's tag/data are captured on grant and held on the bus until the
// sink accepts them (valid/ready). Registered eq/not_eq flags compare the
// captured tag with match_tag while the bus is valid.
// Optional feature macro: TEST1_BUS_ARB_TIMEOUT_EN (abort a stalled transfer
// after TIMEOUT cycles without bus_ready and pulse timeout_err).
module test1_bus_arb #(
  parameter int DW      = 17,
  parameter int TW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rcv_req,
  input  logic [TW-1:0] rcv_tag,
  input  logic [DW-1:0] rcv_data,
  output logic          rcv_gnt,
  input  logic          foo_req,
  input  logic [TW-1:0] foo_tag,
  input  logic [DW-1:0] foo_data,
  output logic          foo_gnt,
  input  logic [TW-1:0] match_tag,
  output logic          bus_valid,
  input  logic          bus_ready,
  output logic [DW-1:0] bus_data,
  output logic          bus_src,
  output logic          eq,
  output logic          not_eq,
  output logic          timeout_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Reject out-of-range timeout limits at elaboration.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("test1_bus_arb: TIMEOUT must be in 1..255");
  end

  state_t        state_q, state_d;
  logic          pri_q, pri_d;          // 0 favours rcv, 1 favours foo
  logic          src_q, src_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [DW-1:0] data_q, data_d;
  logic          rcv_gnt_q, rcv_gnt_d;
  logic          foo_gnt_q, foo_gnt_d;
  logic          eq_q, eq_d;
  logic          not_eq_q, not_eq_d;
  logic          pick_foo;
  logic [TW-1:0] win_tag;
  logic          leave_busy;
`ifdef TEST1_BUS_ARB_TIMEOUT_EN
  logic [7:0]    cnt_q, cnt_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  // Next-state: arbitration and capture in IDLE, handshake/abort in BUSY.
  always_comb begin
    state_d    = state_q;
    pri_d      = pri_q;
    src_d      = src_q;
    tag_d      = tag_q;
    data_d     = data_q;
    rcv_gnt_d  = 1'b0;
    foo_gnt_d  = 1'b0;
    eq_d       = 1'b0;
    not_eq_d   = 1'b0;
    pick_foo   = 1'b0;
    win_tag    = rcv_tag;
    leave_busy = 1'b0;
`ifdef TEST1_BUS_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rcv_req || foo_req) begin
          // foo wins when it is alone, or when both ask and pri favours foo.
          pick_foo  = foo_req && (!rcv_req || pri_q);
          win_tag   = pick_foo ? foo_tag : rcv_tag;
          tag_d     = win_tag;
          data_d    = pick_foo ? foo_data : rcv_data;
          src_d     = pick_foo;
          rcv_gnt_d = !pick_foo;
          foo_gnt_d = pick_foo;
          pri_d     = !pick_foo;
          eq_d      = (win_tag == match_tag);
          not_eq_d  = (win_tag != match_tag);
          state_d   = BUSY;
`ifdef TEST1_BUS_ARB_TIMEOUT_EN
          cnt_d     = 8'd0;
`endif
        end
      end
      default: begin
        if (bus_ready) begin
          leave_busy = 1'b1;
`ifdef TEST1_BUS_ARB_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th stalled cycle: give up on the transfer.
          leave_busy    = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
        if (leave_busy) begin
          state_d = IDLE;
          src_d   = 1'b0;
        end else begin
          eq_d     = (tag_q == match_tag);
          not_eq_d = (tag_q != match_tag);
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pri_q     <= 1'b0;
      src_q     <= 1'b0;
      tag_q     <= '0;
      data_q    <= '0;
      rcv_gnt_q <= 1'b0;
      foo_gnt_q <= 1'b0;
      eq_q      <= 1'b0;
      not_eq_q  <= 1'b0;
`ifdef TEST1_BUS_ARB_TIMEOUT_EN
      cnt_q         <= 8'd0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pri_q     <= pri_d;
      src_q     <= src_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      rcv_gnt_q <= rcv_gnt_d;
      foo_gnt_q <= foo_gnt_d;
      eq_q      <= eq_d;
      not_eq_q  <= not_eq_d;
`ifdef TEST1_BUS_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign rcv_gnt   = rcv_gnt_q;
  assign foo_gnt   = foo_gnt_q;
  assign bus_valid = (state_q == BUSY);
  assign bus_data  = data_q;
  assign bus_src   = src_q;
  assign eq        = eq_q;
  assign not_eq    = not_eq_q;
`ifdef TEST1_BUS_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_test1_bus_arb.sv
// Testbench for test1_bus_arb: table vectors, hand-written corner sequences
// and randomized traffic checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_test1_bus_arb;
  localparam int DW = 17;
  localparam int TW = 4;
  localparam int TIMEOUT = 15;

  // Output flag vector layout: {rcv_gnt, foo_gnt, bus_valid, bus_src, eq, not_eq, timeout_err}
  localparam logic [6:0] RG = 7'h40;
  localparam logic [6:0] FG = 7'h20;
  localparam logic [6:0] V  = 7'h10;
  localparam logic [6:0] S  = 7'h08;
  localparam logic [6:0] EQ = 7'h04;
  localparam logic [6:0] NE = 7'h02;
  localparam logic [6:0] ER = 7'h01;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rcv_req = 1'b0, foo_req = 1'b0, bus_ready = 1'b0;
  logic [TW-1:0] rcv_tag = '0, foo_tag = '0, match_tag = '0;
  logic [DW-1:0] rcv_data = '0, foo_data = '0;
  logic          rcv_gnt, foo_gnt, bus_valid, bus_src, eq, not_eq, timeout_err;
  logic [DW-1:0] bus_data;

  always #5 clk = ~clk;

  test1_bus_arb #(.DW(DW), .TW(TW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .rcv_req(rcv_req), .rcv_tag(rcv_tag), .rcv_data(rcv_data), .rcv_gnt(rcv_gnt),
    .foo_req(foo_req), .foo_tag(foo_tag), .foo_data(foo_data), .foo_gnt(foo_gnt),
    .match_tag(match_tag), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_data(bus_data), .bus_src(bus_src), .eq(eq), .not_eq(not_eq),
    .timeout_err(timeout_err)
  );

  int total = 0;
  int passed = 0;

  // Reference model: one transfer in flight at most, round-robin owner choice.
  bit            m_busy = 1'b0, m_pri = 1'b0, m_src = 1'b0;
  logic [TW-1:0] m_tag = '0;
  logic [DW-1:0] m_data = '0;
  int            m_stall = 0;
  logic [6:0]    e_flags = '0;

  task automatic model_step();
    logic rg = 1'b0, fg = 1'b0, er = 1'b0, foo_wins;
    if (rst) begin
      m_busy = 1'b0; m_pri = 1'b0; m_src = 1'b0; m_data = '0;
    end else if (!m_busy) begin
      if (rcv_req || foo_req) begin
        foo_wins = (rcv_req && foo_req) ? m_pri : foo_req;
        m_busy   = 1'b1;
        m_stall  = 0;
        m_src    = foo_wins;
        m_tag    = foo_wins ? foo_tag : rcv_tag;
        m_data   = foo_wins ? foo_data : rcv_data;
        m_pri    = !foo_wins;
        rg       = !foo_wins;
        fg       = foo_wins;
      end
    end else if (bus_ready) begin
      m_busy = 1'b0;
    end else begin
      m_stall++;
`ifdef TEST1_BUS_ARB_TIMEOUT_EN
      if (m_stall >= TIMEOUT) begin
        m_busy = 1'b0;
        er     = 1'b1;
      end
`endif
    end
    e_flags = {rg, fg, m_busy, m_busy & m_src,
               m_busy && (m_tag == match_tag), m_busy && (m_tag != match_tag), er};
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] ef, input logic [DW-1:0] ed);
    logic [6:0] act;
    act = {rcv_gnt, foo_gnt, bus_valid, bus_src, eq, not_eq, timeout_err};
    total++;
    if (act !== ef || (ef[4] && bus_data !== ed))
      $display("FAIL %s: flags got %b want %b, bus_data got %h want %h", name, act, ef, bus_data, ed);
    else
      passed++;
  endtask

  task automatic check_zero(input string name, input int bad);
    total++;
    if (bad != 0) $display("FAIL %s: bad cycles got %0d want 0", name, bad);
    else passed++;
  endtask

  typedef struct {
    logic          rst;
    logic          rr;
    logic [TW-1:0] rt;
    logic [DW-1:0] rd;
    logic          fr;
    logic [TW-1:0] ft;
    logic [DW-1:0] fd;
    logic [TW-1:0] mt;
    logic          rdy;
    logic [6:0]    ef;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int bad;

    // Table: single rcv grant, reset, alternating grants, foo stall, rcv not_eq.
    tbl[0]  = '{1'b0, 1'b1, 4'h5, 17'h1ABCD, 1'b0, 4'h0, 17'h0, 4'h5, 1'b1, RG|V|EQ, 17'h1ABCD};
    tbl[1]  = '{1'b0, 1'b0, 4'h5, 17'h1ABCD, 1'b0, 4'h0, 17'h0, 4'h5, 1'b1, 7'h00, 17'h0};
    tbl[2]  = '{1'b1, 1'b0, 4'h0, 17'h0,     1'b0, 4'h0, 17'h0, 4'h0, 1'b0, 7'h00, 17'h0};
    for (int i = 3; i <= 9; i++)
      tbl[i] = '{1'b0, 1'b1, 4'h0, 17'h00001, 1'b1, 4'h3, 17'h1FFFF, 4'h0, 1'b1, 7'h00, 17'h0};
    tbl[3].ef = RG|V|EQ;   tbl[3].ed = 17'h00001;
    tbl[5].ef = FG|V|S|NE; tbl[5].ed = 17'h1FFFF;
    tbl[7].ef = RG|V|EQ;   tbl[7].ed = 17'h00001;
    tbl[9].ef = FG|V|S|NE; tbl[9].ed = 17'h1FFFF;
    tbl[10] = '{1'b0, 1'b0, 4'h0, 17'h0, 1'b0, 4'h0, 17'h0, 4'h0, 1'b1, 7'h00, 17'h0};
    tbl[11] = '{1'b0, 1'b0, 4'h0, 17'h0, 1'b1, 4'h3, 17'h12345, 4'h3, 1'b0, FG|V|S|EQ, 17'h12345};
    for (int i = 12; i <= 16; i++)
      tbl[i] = '{1'b0, 1'b1, 4'h7, 17'h0ABCD, 1'b0, 4'h3, 17'h12345, 4'h3, 1'b0, V|S|EQ, 17'h12345};
    tbl[17] = '{1'b0, 1'b1, 4'h7, 17'h0ABCD, 1'b0, 4'h0, 17'h0, 4'h3, 1'b1, 7'h00, 17'h0};
    tbl[18] = '{1'b0, 1'b1, 4'h7, 17'h0ABCD, 1'b0, 4'h0, 17'h0, 4'h3, 1'b1, RG|V|NE, 17'h0ABCD};
    tbl[19] = '{1'b0, 1'b0, 4'h7, 17'h0ABCD, 1'b0, 4'h0, 17'h0, 4'h3, 1'b1, 7'h00, 17'h0};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    check("reset", 7'h00, 17'h0);
    total++;
    if (bus_data !== 17'h0) $display("FAIL reset_data: got %h want 0", bus_data);
    else passed++;

    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst; rcv_req = tbl[i].rr; rcv_tag = tbl[i].rt; rcv_data = tbl[i].rd;
      foo_req = tbl[i].fr; foo_tag = tbl[i].ft; foo_data = tbl[i].fd;
      match_tag = tbl[i].mt; bus_ready = tbl[i].rdy;
      tick();
      check($sformatf("row%0d", i), tbl[i].ef, tbl[i].ed);
      $display("row %0d: gnt r/f=%b%b valid=%b src=%b data=%h eq/ne=%b%b",
               i, rcv_gnt, foo_gnt, bus_valid, bus_src, bus_data, eq, not_eq);
    end

    // Reset in the second BUSY cycle, then simultaneous requests: rcv first.
    rcv_req = 1'b1; rcv_tag = 4'h1; rcv_data = 17'h11111;
    foo_req = 1'b1; foo_tag = 4'h2; foo_data = 17'h02222;
    match_tag = 4'h2; bus_ready = 1'b0;
    tick(); check("rstbusy_grant", FG|V|S|EQ, 17'h02222);
    $display("rstbusy: foo granted data=%h", bus_data);
    tick(); check("rstbusy_busy2", V|S|EQ, 17'h02222);
    rst = 1'b1;
    tick(); check("rstbusy_reset", 7'h00, 17'h0);
    total++;
    if (bus_data !== 17'h0) $display("FAIL rstbusy_data: got %h want 0", bus_data);
    else passed++;
    rst = 1'b0;
    tick(); check("rstbusy_rcv_first", RG|V|NE, 17'h11111);
    $display("rstbusy: rcv granted data=%h", bus_data);
    rcv_req = 1'b0; foo_req = 1'b0; bus_ready = 1'b1;
    tick(); check("rstbusy_done", 7'h00, 17'h0);

`ifdef TEST1_BUS_ARB_TIMEOUT_EN
    // Timeout abort after TIMEOUT stalled cycles, then ready on the limit cycle.
    for (int run = 0; run < 2; run++) begin
      foo_req = 1'b1; foo_tag = 4'h3; foo_data = 17'h0F0F0; match_tag = 4'h3; bus_ready = 1'b0;
      tick(); check("to_grant", FG|V|S|EQ, 17'h0F0F0);
      foo_req = 1'b0;
      bad = 0;
      for (int k = 0; k < TIMEOUT - 1; k++) begin
        tick();
        if (bus_valid !== 1'b1 || timeout_err !== 1'b0) bad++;
      end
      check_zero("to_stall", bad);
      bus_ready = (run == 1);
      tick();
      check(run == 0 ? "to_abort" : "to_ready_wins", run == 0 ? ER : 7'h00, 17'h0);
      bus_ready = 1'b0;
      tick(); check("to_after", 7'h00, 17'h0);
      $display("timeout run %0d: completed", run);
    end
`else
    // Without the timeout feature a stalled transfer waits indefinitely.
    rcv_req = 1'b1; rcv_tag = 4'h5; rcv_data = 17'h05A5A; match_tag = 4'h5; bus_ready = 1'b0;
    tick(); check("stall_grant", RG|V|EQ, 17'h05A5A);
    rcv_req = 1'b0;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (bus_valid !== 1'b1 || timeout_err !== 1'b0 || bus_data !== 17'h05A5A) bad++;
    end
    check_zero("stall_300", bad);
    bus_ready = 1'b1;
    tick(); check("stall_done", 7'h00, 17'h0);
    $display("stall: transfer held 300 cycles then completed");
`endif

    // Randomized traffic against the reference model.
    rst = 1'b1; rcv_req = 1'b0; foo_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!rcv_req && $urandom_range(0, 1) == 1) begin
        rcv_req = 1'b1; rcv_tag = TW'($urandom_range(0, 3)); rcv_data = DW'($urandom);
      end
      if (!foo_req && $urandom_range(0, 1) == 1) begin
        foo_req = 1'b1; foo_tag = TW'($urandom_range(0, 3)); foo_data = DW'($urandom);
      end
      match_tag = TW'($urandom_range(0, 3));
      bus_ready = ($urandom_range(0, 2) != 0);
      tick();
      check($sformatf("rand%0d", c), e_flags, m_data);
      if (e_flags[6] || e_flags[5])
        $display("rand %0d: %s granted data=%h", c, e_flags[5] ? "foo" : "rcv", bus_data);
      if (e_flags[6]) rcv_req = 1'b0;
      if (e_flags[5]) foo_req = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
